// File: rtl/spi_frame_rx.sv
`default_nettype none
// spi_frame_rx: SPI mode-0 receiver that unpacks a timed frame of 12-bit channels into
// framebuffer writes. Revision 1.0
module spi_frame_rx #(
  parameter int c_ledboards = 30,
  parameter int c_bpc       = 12,
  parameter int c_max_time  = 1024,
  localparam int c_channels = c_ledboards * 32,
  localparam int c_addr_w   = $clog2(c_channels),
  localparam int c_time_w   = $clog2(c_max_time)
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_dck,
  input  logic                i_cs,
  input  logic                i_mosi,
  output logic                o_wen,
  output logic [c_addr_w-1:0] o_waddr,
  output logic [c_bpc-1:0]    o_wdata,
  output logic [c_time_w-1:0] o_time,
  output logic                o_done,
  output logic                o_err,
  output logic                o_busy
);

  localparam logic [c_addr_w-1:0] c_last_addr  = c_addr_w'(c_channels - 1);
  localparam logic [15:0]         c_time_lim16 = 16'(c_max_time - 1);
  localparam logic [c_time_w-1:0] c_time_lim   = c_time_w'(c_max_time - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    TAIL = 2'd3
  } state_t;

  state_t state, state_n;

  logic [2:0]          dck_sync, cs_sync, mosi_sync;
  logic                dck_rise, cs_fall, cs_rise;
  logic                bit_valid, byte_done, start;
  logic [2:0]          bit_cnt;
  logic [6:0]          shift;
  logic [7:0]          byte_in;
  logic                hdr_idx;
  logic [7:0]          time_hi;
  logic [15:0]         hdr_word;
  logic [1:0]          phase;
  logic [7:0]          b0;
  logic [3:0]          nib;
  logic [c_addr_w-1:0] addr;
  logic                wr, done_n, err_n, load_time;
  logic [c_bpc-1:0]    wr_data;

  // mosi is taken from the oldest stage: it lines up with the pre-edge dck sample,
  // and mode-0 data is stable for several clk cycles around the rising edge.
  assign dck_rise  = dck_sync[1] & ~dck_sync[2];
  assign cs_fall   = cs_sync[2] & ~cs_sync[1];
  assign cs_rise   = ~cs_sync[2] & cs_sync[1];
  assign byte_in   = {shift, mosi_sync[2]};
  assign bit_valid = dck_rise & ~cs_sync[1] & (state != IDLE);
  assign byte_done = bit_valid & (bit_cnt == 3'd7);
  assign hdr_word  = {time_hi, byte_in};
  assign start     = cs_fall & ((state == IDLE) | (state == TAIL));
  assign o_busy    = (state == HDR) | (state == DATA);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n   = state;
    wr        = 1'b0;
    wr_data   = '0;
    done_n    = 1'b0;
    err_n     = 1'b0;
    load_time = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) state_n = HDR;
      end
      HDR: begin
        if (cs_rise) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else if (byte_done && hdr_idx) begin
          load_time = 1'b1;
          state_n   = DATA;
        end
      end
      DATA: begin
        if (cs_rise) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else if (byte_done && (phase != 2'd0)) begin
          wr      = 1'b1;
          wr_data = (phase == 2'd1) ? {b0, byte_in[7:4]} : {nib, byte_in};
          if (addr == c_last_addr) begin
            done_n  = 1'b1;
            state_n = TAIL;
          end
        end
      end
      TAIL: begin
        if (cs_rise) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      dck_sync  <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      o_wen     <= 1'b0;
      o_waddr   <= '0;
      o_wdata   <= '0;
      o_time    <= '0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
      bit_cnt   <= '0;
      shift     <= '0;
      hdr_idx   <= 1'b0;
      time_hi   <= '0;
      phase     <= '0;
      b0        <= '0;
      nib       <= '0;
      addr      <= '0;
    end else begin
      dck_sync  <= {dck_sync[1:0], i_dck};
      cs_sync   <= {cs_sync[1:0], i_cs};
      mosi_sync <= {mosi_sync[1:0], i_mosi};
      o_wen     <= wr;
      o_done    <= done_n;
      o_err     <= err_n;
      if (load_time)
        o_time <= (hdr_word > c_time_lim16) ? c_time_lim : hdr_word[c_time_w-1:0];
      if (wr) begin
        o_waddr <= addr;
        o_wdata <= wr_data;
      end
      // A new frame discards any partial byte left by an aborted one.
      if (start) begin
        bit_cnt <= '0;
        hdr_idx <= 1'b0;
        phase   <= '0;
        addr    <= '0;
      end else if (bit_valid) begin
        shift   <= byte_in[6:0];
        bit_cnt <= bit_cnt + 3'd1;
        if (byte_done && (state == HDR)) begin
          hdr_idx <= 1'b1;
          time_hi <= byte_in;
        end
        if (byte_done && (state == DATA)) begin
          case (phase)
            2'd0: begin
              b0    <= byte_in;
              phase <= 2'd1;
            end
            2'd1: begin
              nib   <= byte_in[3:0];
              phase <= 2'd2;
            end
            default: phase <= 2'd0;
          endcase
          if (wr) addr <= (addr == c_last_addr) ? '0 : addr + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/spi_frame_rx.md
SPI_FRAME_RX -- requirements
Module: spi_frame_rx

Interface
REQ-001 The block SHALL have parameter c_ledboards, default 30, number of LED boards (32 channels each).
REQ-002 The block SHALL have parameter c_bpc, default 12, bits per channel; the packing below is defined for 12 only.
REQ-003 The block SHALL have parameter c_max_time, default 1024, exclusive upper bound of the transition time.
REQ-004 The block SHALL derive localparams c_channels = c_ledboards*32, c_addr_w = $clog2(c_channels) and c_time_w = $clog2(c_max_time).
REQ-005 The block SHALL have port i_clk, input, 1, the system clock; it is the block's only clock.
REQ-006 The block SHALL have port i_rstn, input, 1, an asynchronous active-low reset.
REQ-007 The block SHALL have port i_dck, input, 1, the SPI clock, asynchronous to i_clk.
REQ-008 The block SHALL have port i_cs, input, 1, the SPI chip select, active low, asynchronous.
REQ-009 The block SHALL have port i_mosi, input, 1, the SPI data line, asynchronous.
REQ-010 The block SHALL have port o_wen, output, 1, a one-cycle framebuffer write strobe.
REQ-011 The block SHALL have port o_waddr, output, c_addr_w, the framebuffer write address.
REQ-012 The block SHALL have port o_wdata, output, c_bpc, the framebuffer write data.
REQ-013 The block SHALL have port o_time, output, c_time_w, the transition time of the current frame.
REQ-014 The block SHALL have port o_done, output, 1, a one-cycle pulse when a complete frame has been received.
REQ-015 The block SHALL have port o_err, output, 1, a one-cycle pulse when a frame is aborted.
REQ-016 The block SHALL have port o_busy, output, 1, high while a frame is in progress.

Function
REQ-017 The block SHALL pass i_dck, i_cs and i_mosi each through a 3-flop synchronizer, and SHALL detect dck rising edges on the last two synchronizer stages.
REQ-018 Correct operation SHALL require an i_dck frequency of at most i_clk/8.
REQ-019 The block SHALL use SPI mode 0: mosi sampled on dck rising edges while cs is low, MSB first, 8-bit bytes.
REQ-020 A synchronized cs falling edge SHALL clear the bit counter and move the FSM IDLE->HDR; o_busy SHALL be 1 in HDR and DATA, and 0 otherwise.
REQ-021 In HDR the first two bytes SHALL form a 16-bit big-endian time T; o_time SHALL be loaded with min(T, c_max_time-1) when the second byte completes, and the FSM SHALL then enter DATA.
REQ-022 In DATA, bytes SHALL be taken in triples (b0,b1,b2) giving channel n = {b0, b1[7:4]} and channel n+1 = {b1[3:0], b2}, with n starting at 0 and incrementing by 2 per triple.
REQ-023 Channel n SHALL be written when b1 completes, and channel n+1 when b2 completes.
REQ-024 o_wen SHALL be high for exactly the one i_clk cycle after the cycle in which the completing bit is shifted in, with o_waddr/o_wdata valid in that same cycle.
REQ-025 When channel c_channels-1 is written, o_done SHALL pulse in the same cycle as that o_wen, and the FSM SHALL enter TAIL.
REQ-026 In TAIL, further bytes SHALL be ignored (no o_wen) until cs deasserts, after which the FSM SHALL return to IDLE.
REQ-027 If cs deasserts in HDR or DATA, o_err SHALL pulse once, the FSM SHALL return to IDLE, o_done SHALL not pulse, and partial-byte bits SHALL be discarded.
REQ-028 A cs falling edge while in TAIL or IDLE SHALL start a new frame from HDR; o_time SHALL hold its value until the next HDR completes.
REQ-029 o_done and o_err SHALL never be asserted in the same cycle; o_wen SHALL never assert outside DATA.
REQ-030 The write address counter SHALL be c_addr_w bits wide and SHALL never exceed c_channels-1.

Reset
REQ-031 While i_rstn=0, all outputs SHALL be 0, the FSM SHALL be in IDLE, and the synchronizers and counters SHALL be cleared.
REQ-032 Reset asserted mid-frame SHALL abort the frame without an o_err pulse.
REQ-033 After reset release, the block SHALL ignore a cs already low until cs is seen high and then falls again.

Verification
REQ-034 Full frame, T=0x0064, 1440 data bytes of incrementing pattern -> 960 o_wen pulses at addresses 0..959 in order, o_time=100, one o_done, no o_err.
REQ-035 Header 0xFFFF -> o_time=1023 (saturated).
REQ-036 Data bytes AB CD EF -> writes (0,0xABC) then (1,0xDEF).
REQ-037 cs raised after 500 data bytes -> o_err pulse, no o_done, o_busy=0, and the next full frame is received correctly.
REQ-038 Full frame plus 10 extra bytes -> exactly 960 o_wen pulses and one o_done.
REQ-039 i_rstn pulsed low mid-DATA, then a full frame -> outputs are 0 during reset, no o_err pulse, and the subsequent frame is correct.
